// File: rtl/snax_reqrsp_to_tcdm_bank.sv
// Bridges a reqrsp request/response port onto a single TCDM bank with fixed
// one-cycle read latency; read credits bound the outstanding reads to the response FIFO depth.
module snax_reqrsp_to_tcdm_bank #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned RspDepth  = 4,
  localparam int unsigned StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 q_valid_i,
  output logic                 q_ready_o,
  input  logic                 q_write_i,
  input  logic [AddrWidth-1:0] q_addr_i,
  input  logic [DataWidth-1:0] q_data_i,
  input  logic [StrbWidth-1:0] q_strb_i,
  output logic                 p_valid_o,
  input  logic                 p_ready_i,
  output logic [DataWidth-1:0] p_data_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [StrbWidth-1:0] mem_be_o,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  localparam int unsigned CntW = $clog2(RspDepth + 1);
  localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CntW-1:0]      occ_q, occ_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic                 rd_pend_q;
  logic [DataWidth-1:0] fifo_q [RspDepth];

  logic credit_ok, rd_grant, fifo_empty, p_pop, fifo_pop, fifo_push;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(RspDepth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  // Writes bypass the credit check; reads need a free response slot.
  assign credit_ok   = cnt_q < CntW'(RspDepth);
  assign mem_req_o   = q_valid_i & (q_write_i | credit_ok);
  assign q_ready_o   = mem_req_o & mem_gnt_i;
  assign rd_grant    = q_ready_o & ~q_write_i;

  assign mem_we_o    = q_write_i;
  assign mem_addr_o  = q_addr_i;
  assign mem_wdata_o = q_data_i;
  assign mem_be_o    = q_strb_i;

  // Fall-through: an empty FIFO presents the bank data directly.
  assign fifo_empty  = (occ_q == '0);
  assign p_valid_o   = ~fifo_empty | rd_pend_q;
  assign p_data_o    = fifo_empty ? mem_rdata_i : fifo_q[rd_ptr_q];
  assign p_pop       = p_valid_o & p_ready_i;
  assign fifo_pop    = ~fifo_empty & p_ready_i;
  assign fifo_push   = rd_pend_q & ~(fifo_empty & p_ready_i);

  always_comb begin
    cnt_d    = cnt_q;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({rd_grant, p_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    case ({fifo_push, fifo_pop})
      2'b10:   occ_d = occ_q + CntW'(1);
      2'b01:   occ_d = occ_q - CntW'(1);
      default: occ_d = occ_q;
    endcase
    if (fifo_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (fifo_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      occ_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      occ_q     <= occ_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_pend_q <= rd_grant;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    if (fifo_push) fifo_q[wr_ptr_q] <= mem_rdata_i;
  end

  a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(p_pop && cnt_q == '0));
  a_fifo_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_push && !fifo_pop && occ_q == CntW'(RspDepth)));

endmodule

// File: tb/tb_snax_reqrsp_to_tcdm_bank.sv
// Scoreboard bench: drivers queue the expected read data on acceptance, a
// negedge monitor pops and compares every delivered response.
module tb_snax_reqrsp_to_tcdm_bank;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        q_valid_i, q_ready_o, q_write_i;
  logic [47:0] q_addr_i;
  logic [63:0] q_data_i;
  logic [7:0]  q_strb_i;
  logic        p_valid_o, p_ready_i;
  logic [63:0] p_data_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o;
  logic [47:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_be_o;
  logic [63:0] mem_rdata_i;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb [$];
  int          waited;

  snax_reqrsp_to_tcdm_bank dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .q_valid_i(q_valid_i), .q_ready_o(q_ready_o), .q_write_i(q_write_i),
    .q_addr_i(q_addr_i), .q_data_i(q_data_i), .q_strb_i(q_strb_i),
    .p_valid_o(p_valid_o), .p_ready_i(p_ready_i), .p_data_o(p_data_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Bank model: read data is {16'hA5A5, addr}, valid one cycle after grant.
  always @(posedge clk_i) begin
    if (mem_req_o && mem_gnt_i && !mem_we_o) mem_rdata_i <= {16'hA5A5, mem_addr_o};
    else                                     mem_rdata_i <= 64'hBAD0_BAD0_BAD0_BAD0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Holds a read request until accepted, then queues its expected response.
  task automatic do_read(input logic [47:0] a, input logic [63:0] exp, output int w);
    bit done = 0;
    q_valid_i = 1'b1; q_write_i = 1'b0; q_addr_i = a; q_data_i = '0; q_strb_i = '0;
    w = 0;
    while (!done) begin
      @(negedge clk_i);
      if (q_ready_o) begin
        sb.push_back(exp);
        done = 1;
      end else if (w >= 20) begin
        n_vec++; n_err++;
        $display("FAIL read_accept_timeout: addr %h never accepted", a);
        done = 1;
      end else begin
        w++;
      end
      step();
    end
  endtask

  // Monitor: response data order and hold-while-stalled stability.
  logic        hold = 1'b0;
  logic [63:0] held;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("p_valid_hold", {63'd0, p_valid_o}, 64'd1);
        chk("p_data_hold", p_data_o, held);
      end
      if (p_valid_o && p_ready_i) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_rsp: got data %h with no read outstanding", p_data_o);
        end else begin
          chk("rsp_data", p_data_o, sb.pop_front());
        end
      end
      hold = p_valid_o && !p_ready_i;
      held = p_data_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; q_valid_i = 1'b1; q_write_i = 1'b0; q_addr_i = 48'h40;
    q_data_i = '0; q_strb_i = '0; p_ready_i = 1'b1; mem_gnt_i = 1'b1;
    repeat (2) step();
    // Reset: response side idle, request side follows q_valid only.
    @(negedge clk_i);
    chk("rst_p_valid", {63'd0, p_valid_o}, 64'd0);
    chk("rst_mem_req", {63'd0, mem_req_o}, 64'd1);
    chk("rst_q_ready", {63'd0, q_ready_o}, 64'd1);
    chk("rst_cnt", 64'(dut.cnt_q), 64'd0);
    step();
    q_valid_i = 1'b0;
    step();
    rst_ni = 1'b1;

    // Single read right after reset release, one-cycle latency.
    do_read(48'h40, 64'hA5A5_0000_0000_0040, waited);
    chk("first_accept_wait", 64'(waited), 64'd0);
    q_valid_i = 1'b0;
    @(negedge clk_i);
    chk("read_latency_valid", {63'd0, p_valid_o}, 64'd1);
    chk("read_latency_data", p_data_o, 64'hA5A5_0000_0000_0040);
    step();
    @(negedge clk_i);
    chk("single_cnt", 64'(dut.cnt_q), 64'd0);
    step();

    // Five back-to-back reads with response stalled: fifth blocked by credits.
    p_ready_i = 1'b0;
    do_read(48'h1000, 64'hA5A5_0000_0000_1000, waited); chk("b2b_wait0", 64'(waited), 64'd0);
    do_read(48'h1008, 64'hA5A5_0000_0000_1008, waited); chk("b2b_wait1", 64'(waited), 64'd0);
    do_read(48'h1010, 64'hA5A5_0000_0000_1010, waited); chk("b2b_wait2", 64'(waited), 64'd0);
    do_read(48'h1018, 64'hA5A5_0000_0000_1018, waited); chk("b2b_wait3", 64'(waited), 64'd0);
    q_addr_i = 48'h1020;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("full_q_ready", {63'd0, q_ready_o}, 64'd0);
      chk("full_cnt", 64'(dut.cnt_q), 64'd4);
      step();
    end
    // Pop in a full cycle does not free the credit until the next cycle.
    p_ready_i = 1'b1;
    do_read(48'h1020, 64'hA5A5_0000_0000_1020, waited);
    chk("full_pop_wait", 64'(waited), 64'd1);
    q_valid_i = 1'b0;
    repeat (8) step();
    chk("b2b_drained", 64'(sb.size()), 64'd0);

    // Write at full credits is forwarded and produces no response.
    p_ready_i = 1'b0;
    do_read(48'h2000, 64'hA5A5_0000_0000_2000, waited);
    do_read(48'h2008, 64'hA5A5_0000_0000_2008, waited);
    do_read(48'h2010, 64'hA5A5_0000_0000_2010, waited);
    do_read(48'h2018, 64'hA5A5_0000_0000_2018, waited);
    q_write_i = 1'b1; q_addr_i = 48'h100; q_data_i = 64'hDEADBEEF; q_strb_i = 8'h0F;
    @(negedge clk_i);
    chk("wr_mem_req", {63'd0, mem_req_o}, 64'd1);
    chk("wr_mem_we", {63'd0, mem_we_o}, 64'd1);
    chk("wr_q_ready", {63'd0, q_ready_o}, 64'd1);
    chk("wr_addr", 64'(mem_addr_o), 64'h100);
    chk("wr_wdata", mem_wdata_o, 64'hDEADBEEF);
    chk("wr_be", 64'(mem_be_o), 64'h0F);
    step();
    q_valid_i = 1'b0; q_write_i = 1'b0;
    @(negedge clk_i);
    chk("wr_cnt", 64'(dut.cnt_q), 64'd4);
    step();
    p_ready_i = 1'b1;
    repeat (8) step();
    chk("wr_drained", 64'(sb.size()), 64'd0);

    // Grant withheld for three cycles.
    mem_gnt_i = 1'b0;
    q_valid_i = 1'b1; q_write_i = 1'b0; q_addr_i = 48'h200;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("nognt_q_ready", {63'd0, q_ready_o}, 64'd0);
      chk("nognt_mem_req", {63'd0, mem_req_o}, 64'd1);
      chk("nognt_cnt", 64'(dut.cnt_q), 64'd0);
      step();
    end
    mem_gnt_i = 1'b1;
    do_read(48'h200, 64'hA5A5_0000_0000_0200, waited);
    chk("gnt_accept_wait", 64'(waited), 64'd0);
    q_valid_i = 1'b0;
    repeat (4) step();

    // Grant and pop in the same cycle at cnt=2.
    p_ready_i = 1'b0;
    do_read(48'h3000, 64'hA5A5_0000_0000_3000, waited);
    do_read(48'h3008, 64'hA5A5_0000_0000_3008, waited);
    q_valid_i = 1'b0;
    step();
    p_ready_i = 1'b1;
    do_read(48'h3010, 64'hA5A5_0000_0000_3010, waited);
    chk("popgnt_wait", 64'(waited), 64'd0);
    q_valid_i = 1'b0;
    @(negedge clk_i);
    chk("popgnt_cnt", 64'(dut.cnt_q), 64'd2);
    step();
    repeat (6) step();
    chk("popgnt_drained", 64'(sb.size()), 64'd0);

    // Reset while read data is in flight: response is discarded.
    p_ready_i = 1'b0;
    do_read(48'h4000, 64'hA5A5_0000_0000_4000, waited);
    q_valid_i = 1'b0;
    rst_ni = 1'b0;
    sb.delete();
    step();
    rst_ni = 1'b1;
    p_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("rst_mid_p_valid", {63'd0, p_valid_o}, 64'd0);
      chk("rst_mid_cnt", 64'(dut.cnt_q), 64'd0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/snax_reqrsp_to_tcdm_bank.md
SNAX_REQRSP_TO_TCDM_BANK -- requirements
Module: snax_reqrsp_to_tcdm_bank

Interface
REQ-001 SHALL have parameter AddrWidth, default 48, request address width.
REQ-002 SHALL have parameter DataWidth, default 64, data width; StrbWidth = DataWidth/8.
REQ-003 SHALL have parameter RspDepth, default 4, maximum outstanding reads (credits); legal range 1..16.
REQ-004 SHALL have port clk_i  in  1  clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports q_valid_i in 1 / q_ready_o out 1  reqrsp request handshake.
REQ-007 SHALL have ports q_write_i in 1, q_addr_i in AddrWidth, q_data_i in DataWidth, q_strb_i in StrbWidth  request payload.
REQ-008 SHALL have ports p_valid_o out 1 / p_ready_i in 1 / p_data_o out DataWidth  read-response channel.
REQ-009 SHALL have ports mem_req_o out 1 / mem_gnt_i in 1  bank request handshake.
REQ-010 SHALL have ports mem_we_o out 1, mem_addr_o out AddrWidth, mem_wdata_o out DataWidth, mem_be_o out StrbWidth  bank payload.
REQ-011 SHALL have port mem_rdata_i  in  DataWidth  read data, valid exactly 1 cycle after a granted read; no backpressure.

Function
REQ-012 SHALL keep credit counter cnt (0..RspDepth) = reads granted and not yet popped at p side.
REQ-013 SHALL assert mem_req_o = q_valid_i & (q_write_i | cnt < RspDepth), combinationally.
REQ-014 SHALL drive q_ready_o = mem_req_o & mem_gnt_i; request accepted in that same cycle.
REQ-015 SHALL pass q_write_i, q_addr_i, q_data_i, q_strb_i unchanged to mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o.
REQ-016 SHALL never stall writes on credits; writes produce no p response.
REQ-017 SHALL register rd_pend <= mem_req_o & mem_gnt_i & ~q_write_i; rd_pend marks mem_rdata_i valid.
REQ-018 SHALL increment cnt on granted read, decrement on p_valid_o & p_ready_i, hold on both or neither.
REQ-019 SHALL buffer responses in a RspDepth-entry fall-through FIFO: when empty and rd_pend, p_valid_o=1 and p_data_o=mem_rdata_i same cycle.
REQ-020 SHALL push mem_rdata_i into FIFO when rd_pend & ~(fall-through pop); read latency q accept -> p_valid_o = 1 cycle.
REQ-021 SHALL present responses in request order; p_data_o held stable while p_valid_o & ~p_ready_i.
REQ-022 SHALL never overflow FIFO: credit check guarantees occupancy + rd_pend <= RspDepth.
REQ-023 SHALL, at cnt==RspDepth, block reads (mem_req_o=0 for read) while still forwarding writes.
REQ-024 SHALL, when cnt==RspDepth and a pop occurs same cycle, still block reads that cycle (credit frees next cycle).
REQ-025 SHALL wrap FIFO pointers modulo RspDepth; simultaneous push and pop keeps occupancy.
REQ-026 SHALL flag assertion error if cnt underflows or FIFO pushes when full.

Reset
REQ-027 SHALL on rst_ni low clear cnt=0, rd_pend=0, FIFO empty, p_valid_o=0; mem_req_o/q_ready_o follow q_valid_i only.
REQ-028 SHALL discard in-flight read data when reset asserts mid-operation; no response after reset release.
REQ-029 SHALL accept requests the first cycle after rst_ni rises.

Verification
REQ-030 Single read addr 0x40, gnt=1, p_ready=1 -> q_ready same cycle, p_valid next cycle with mem_rdata, cnt back to 0.
REQ-031 Five back-to-back reads, p_ready=0, gnt=1 -> 4 granted, 5th stalled (q_ready=0), cnt=4; p_ready=1 -> all 5 returned in order.
REQ-032 Write 0xDEADBEEF strb 0x0F while cnt=4 -> mem_req=1, mem_we=1, accepted, no p_valid.
REQ-033 mem_gnt_i=0 for 3 cycles with q_valid=1 read -> q_ready=0, cnt unchanged, accept on 4th cycle.
REQ-034 Pop and grant same cycle at cnt=2 -> cnt stays 2, FIFO order preserved.
REQ-035 rst_ni low one cycle after granted read -> p_valid_o=0 after release, cnt=0.
